// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I opcode, field and loader-state constants
package riscv_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SUB = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [1:0] KIND_R   = 2'd0;
  localparam logic [1:0] KIND_LW  = 2'd1;
  localparam logic [1:0] KIND_SW  = 2'd2;
  localparam logic [1:0] KIND_BEQ = 2'd3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef logic [1:0] state_t;
  localparam state_t ST_LOAD  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - combinational symbolic-instruction to RV32I word encoder
module instr_encoder
  import riscv_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic [2:0]  alu,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  logic [2:0] f3;
  logic [6:0] f7;

  always_comb begin
    word  = '0;
    legal = 1'b0;
    f3    = F3_ADD;
    f7    = F7_BASE;
    case (kind)
      KIND_R: begin
        legal = 1'b1;
        case (alu)
          ALU_ADD: f3 = F3_ADD;
          ALU_SUB: begin
            f3 = F3_SUB;
            f7 = F7_SUB;
          end
          ALU_AND: f3 = F3_AND;
          ALU_OR:  f3 = F3_OR;
          ALU_SLT: f3 = F3_SLT;
          default: legal = 1'b0;
        endcase
        word = {f7, rs2, rs1, f3, rd, OP_R};
      end
      // lw/sw only carry 12 immediate bits, so bit 12 must be a pure sign copy
      KIND_LW: begin
        legal = (imm[12] == imm[11]);
        word  = {imm[11:0], rs1, F3_WORD, rd, OP_LW};
      end
      KIND_SW: begin
        legal = (imm[12] == imm[11]);
        word  = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_SW};
      end
      default: begin
        legal = ~imm[0];
        word  = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BEQ};
      end
    endcase
  end

endmodule

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - encodes handshaked instructions and writes them to sequential imem words
module imem_program_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [2:0]        in_alu,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full,
  output logic              err
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       word_q;
  logic              last_q;
  logic [31:0]       enc_word;
  logic              enc_legal;

  instr_encoder u_encoder (
    .kind  (in_kind),
    .alu   (in_alu),
    .rd    (in_rd),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .imm   (in_imm),
    .word  (enc_word),
    .legal (enc_legal)
  );

  assign in_ready   = (state == ST_LOAD);
  // clear must suppress a strobe already in progress, hence the gate here
  assign imem_we    = (state == ST_WRITE) && !clear;
  assign imem_addr  = addr;
  assign imem_wdata = word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_LOAD;
      addr   <= '0;
      word_q <= '0;
      last_q <= 1'b0;
      count  <= '0;
      done   <= 1'b0;
      full   <= 1'b0;
      err    <= 1'b0;
    end else if (clear) begin
      state  <= ST_LOAD;
      addr   <= '0;
      last_q <= 1'b0;
      count  <= '0;
      done   <= 1'b0;
      full   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            if (enc_legal) begin
              word_q <= enc_word;
              last_q <= in_last;
              state  <= ST_WRITE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          count <= count + (ADDR_W + 1)'(1);
          if (last_q) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (&addr) begin
            state <= ST_DONE;
            done  <= 1'b1;
            full  <= 1'b1;
          end else begin
            addr  <= addr + ADDR_W'(1);
            state <= ST_LOAD;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - scoreboard bench for the imem program loader
module tb_imem_program_loader;

  localparam int ADDR_W = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_kind = '0;
  logic [2:0]        in_alu = '0;
  logic [4:0]        in_rd = '0;
  logic [4:0]        in_rs1 = '0;
  logic [4:0]        in_rs2 = '0;
  logic [12:0]       in_imm = '0;
  logic              in_last = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              done;
  logic              full;
  logic              err;

  int                n_cmp = 0;
  int                n_bad = 0;
  exp_t              sb[$];
  logic [ADDR_W-1:0] exp_addr = '0;

  imem_program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_alu     (in_alu),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .done       (done),
    .full       (full),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected write
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: addr %0d data 0x%08h with nothing expected", imem_addr, imem_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_addr", 32'(imem_addr), 32'(e.addr));
        chk("strobe_data", imem_wdata, e.data);
      end
    end
  end

  task automatic set_instr(input logic [1:0] k, input logic [2:0] a, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                           input logic last);
    in_kind = k; in_alu = a; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
  endtask

  // push=1 queues an expected write at the next bench address
  task automatic send(input logic [1:0] k, input logic [2:0] a, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                      input logic last, input logic push, input logic [31:0] exp_word);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      set_instr(k, a, rd, rs1, rs2, imm, last);
      in_valid = 1'b1;
      if (push) begin
        sb.push_back('{addr: exp_addr, data: exp_word});
        exp_addr = exp_addr + 1'b1;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    exp_addr = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", {29'd0, done, full, err}, 32'd0);

    // R-type pair
    send(2'd0, 3'b000, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 1'b1, 32'h002081B3);
    send(2'd0, 3'b001, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 1'b1, 32'h402081B3);
    repeat (2) @(negedge clk);
    chk("rtype_count", 32'(count), 32'd2);
    do_clear();

    // memory ops and a terminating branch
    send(2'd1, 3'b000, 5'd5, 5'd1, 5'd0, 13'd8, 1'b0, 1'b1, 32'h0080A283);
    send(2'd2, 3'b000, 5'd0, 5'd2, 5'd5, 13'd12, 1'b0, 1'b1, 32'h00512623);
    send(2'd3, 3'b000, 5'd0, 5'd1, 5'd2, 13'h1FFC, 1'b1, 1'b1, 32'hFE208EE3);
    repeat (2) @(negedge clk);
    chk("last_done", 32'(done), 32'd1);
    chk("last_full", 32'(full), 32'd0);
    chk("last_in_ready", 32'(in_ready), 32'd0);
    chk("last_count", 32'(count), 32'd3);
    do_clear();
    chk("clear_done", 32'(done), 32'd0);
    chk("clear_count", 32'(count), 32'd0);

    // illegal instructions are dropped and flag err
    send(2'd0, 3'b100, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 1'b0, 32'd0);
    chk("bad_alu_err", 32'(err), 32'd1);
    chk("bad_alu_ready", 32'(in_ready), 32'd1);
    send(2'd3, 3'b000, 5'd0, 5'd1, 5'd2, 13'd3, 1'b0, 1'b0, 32'd0);
    chk("bad_beq_count", 32'(count), 32'd0);
    send(2'd1, 3'b000, 5'd5, 5'd1, 5'd0, 13'h1000, 1'b0, 1'b0, 32'd0);
    chk("bad_lw_addr", 32'(imem_addr), 32'd0);
    send(2'd0, 3'b000, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 1'b1, 32'h002081B3);
    repeat (2) @(negedge clk);
    chk("after_bad_count", 32'(count), 32'd1);
    chk("err_sticky", 32'(err), 32'd1);
    do_clear();
    chk("clear_err", 32'(err), 32'd0);

    // in_valid held high: ready toggles, four writes fill memory, then hold
    @(negedge clk);
    set_instr(2'd0, 3'b011, 5'd7, 5'd6, 5'd4, 13'd0, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("stream_ready", 32'(in_ready), (i < 8 && i % 2 == 0) ? 32'd1 : 32'd0);
      if (i < 8 && i % 2 == 0) begin
        sb.push_back('{addr: exp_addr, data: 32'h004363B3});
        exp_addr = exp_addr + 1'b1;
      end
    end
    chk("full_done", 32'(done), 32'd1);
    chk("full_full", 32'(full), 32'd1);
    chk("full_count", 32'(count), 32'd4);
    in_valid = 1'b0;
    do_clear();
    chk("clear_full", 32'(full), 32'd0);

    // clear aborts an in-flight write
    send(2'd0, 3'b010, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 1'b1, 32'h0020F1B3);
    send(2'd0, 3'b101, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 1'b0, 32'd0);
    clear = 1'b1;
    #1 chk("clear_we", 32'(imem_we), 32'd0);
    @(posedge clk);
    #1 clear = 1'b0;
    exp_addr = '0;
    chk("clear_wr_count", 32'(count), 32'd0);
    chk("clear_wr_addr", 32'(imem_addr), 32'd0);
    chk("clear_wr_ready", 32'(in_ready), 32'd1);

    // async reset mid-program
    send(2'd0, 3'b101, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 1'b1, 32'h0020A1B3);
    send(2'd0, 3'b000, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b0;
    #1 chk("rst_mid_we", 32'(imem_we), 32'd0);
    chk("rst_mid_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_addr = '0;
    @(negedge clk);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_flags", {29'd0, done, full, err}, 32'd0);
    send(2'd0, 3'b000, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 1'b1, 32'h002081B3);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
